// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: multi-digit BCD stopwatch advanced by rising edges of a
// divided clock that is sampled as data in the clk_i domain.
//
// Ports:
//   clk_i, rst_n_i   system clock, async active-low reset
//   slow_clk_i       divided clock, synchronized and edge-detected here
//   start_i          pulse: IDLE/PAUSE -> RUN
//   stop_i           pulse: RUN -> PAUSE
//   clear_i          pulse: zero count, -> IDLE
//   lap_i            pulse: toggle lap freeze (only with LAP_HOLD_EN)
//   bcd_o            count, digit 0 (units) in [3:0]
//   running_o        high while in RUN
//   tick_o           one-cycle pulse per slow_clk_i rising edge
//   wrap_o           one-cycle pulse on all-9s -> 0 rollover
//
// Optional feature macro: LAP_HOLD_EN (adds lap_i and a lap register).

module bcd_stopwatch #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                slow_clk_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                clear_i,
`ifdef LAP_HOLD_EN
  input  logic                lap_i,
`endif
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                running_o,
  output logic                tick_o,
  output logic                wrap_o
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;
  logic                   wrap_q, wrap_d;
  logic                   run_q, run_d;
  logic [W-1:0]           cnt_q, cnt_d;
  logic [W-1:0]           cnt_inc;
  logic                   inc_carry;
  logic                   tick;

  // Synchronizer shift chain followed by the edge-detect history flop.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], slow_clk_i};
    prev_d = sync_q[SYNC_STAGES-1];
    tick   = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Ripple-carry BCD increment; the final carry marks the rollover.
  always_comb begin : inc_blk
    logic       c;
    logic [3:0] dig;
    c       = 1'b1;
    cnt_inc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      if (c) begin
        if (dig == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = dig + 4'd1;
          c = 1'b0;
        end
      end else begin
        cnt_inc[4*i +: 4] = dig;
      end
    end
    inc_carry = c;
  end

  // Control: clear beats stop beats start; a tick only counts when
  // no control event claims the cycle and the state was already RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (stop_i && state_q == RUN) begin
      state_d = PAUSE;
    end else if (start_i && state_q != RUN) begin
      state_d = RUN;
    end else if (state_q == RUN && tick) begin
      cnt_d  = cnt_inc;
      wrap_d = inc_carry;
    end
    run_d  = (state_d == RUN);
    tick_d = tick;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  end

  assign running_o = run_q;
  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;

`ifdef LAP_HOLD_EN
  logic [W-1:0] lap_q, lap_d;
  logic         frz_q, frz_d;

  // Capture uses cnt_q, so a lap on a tick cycle holds the
  // pre-increment value.
  always_comb begin
    lap_d = lap_q;
    frz_d = frz_q;
    if (clear_i) begin
      lap_d = '0;
      frz_d = 1'b0;
    end else if (lap_i) begin
      if (frz_q) begin
        frz_d = 1'b0;
      end else begin
        lap_d = cnt_q;
        frz_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lap_q <= '0;
      frz_q <= 1'b0;
    end else begin
      lap_q <= lap_d;
      frz_q <= frz_d;
    end
  end

  assign bcd_o = frz_q ? lap_q : cnt_q;
`else
  assign bcd_o = cnt_q;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed vectors plus hand-written corner sequences
// for bcd_stopwatch (DIGITS=4, SYNC_STAGES=2).

module tb_bcd_stopwatch;

  logic        clk;
  logic        rst_n;
  logic        slow;
  logic        start;
  logic        stop;
  logic        clear;
`ifdef LAP_HOLD_EN
  logic        lap;
`endif
  logic [15:0] bcd;
  logic        running;
  logic        tick;
  logic        wrap;

  int ncmp = 0;
  int nerr = 0;

  bcd_stopwatch #(
    .DIGITS      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .slow_clk_i (slow),
    .start_i    (start),
    .stop_i     (stop),
    .clear_i    (clear),
`ifdef LAP_HOLD_EN
    .lap_i      (lap),
`endif
    .bcd_o      (bcd),
    .running_o  (running),
    .tick_o     (tick),
    .wrap_o     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        clear;
    logic        slow;
    logic [15:0] bcd;
    logic        run;
    logic        tick;
    logic        wrap;
  } vec_t;

  vec_t vq[$];

  function automatic void push(logic a, logic b, logic c, logic s,
                               logic [15:0] e_bcd, logic e_run,
                               logic e_tick, logic e_wrap);
    vec_t v;
    v.start = a;
    v.stop  = b;
    v.clear = c;
    v.slow  = s;
    v.bcd   = e_bcd;
    v.run   = e_run;
    v.tick  = e_tick;
    v.wrap  = e_wrap;
    vq.push_back(v);
  endfunction

  // One slow period: 2 cycles high, 2 low. The count and tick_o
  // change on the 3rd edge after slow first samples high.
  function automatic void add_period(logic [15:0] b, logic [15:0] a,
                                     logic r);
    push(0, 0, 0, 1, b, r, 0, 0);
    push(0, 0, 0, 1, b, r, 0, 0);
    push(0, 0, 0, 0, a, r, 1, 0);
    push(0, 0, 0, 0, a, r, 0, 0);
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(logic a, logic b, logic c, logic s);
    start = a;
    stop  = b;
    clear = c;
    slow  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(int n);
    repeat (n) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    int tc;
    rst_n = 1'b0;
    slow  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
`ifdef LAP_HOLD_EN
    lap   = 1'b0;
`endif

    // Test 1 and 2 vectors
    push(1, 0, 0, 0, 16'h0000, 1, 0, 0);
    add_period(16'h0000, 16'h0001, 1);
    add_period(16'h0001, 16'h0002, 1);
    add_period(16'h0002, 16'h0003, 1);
    add_period(16'h0003, 16'h0004, 1);
    add_period(16'h0004, 16'h0005, 1);
    add_period(16'h0005, 16'h0006, 1);
    add_period(16'h0006, 16'h0007, 1);
    add_period(16'h0007, 16'h0008, 1);
    add_period(16'h0008, 16'h0009, 1);
    add_period(16'h0009, 16'h0010, 1);
    add_period(16'h0010, 16'h0011, 1);
    add_period(16'h0011, 16'h0012, 1);
    push(0, 1, 0, 0, 16'h0012, 0, 0, 0);
    add_period(16'h0012, 16'h0012, 0);
    add_period(16'h0012, 16'h0012, 0);
    add_period(16'h0012, 16'h0012, 0);
    push(1, 0, 0, 0, 16'h0012, 1, 0, 0);
    add_period(16'h0012, 16'h0013, 1);
    add_period(16'h0013, 16'h0014, 1);

    #12;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_run", {15'd0, running}, 16'd0);
    chk("rst_tick", {15'd0, tick}, 16'd0);
    chk("rst_wrap", {15'd0, wrap}, 16'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].start, vq[i].stop, vq[i].clear, vq[i].slow);
      chk($sformatf("v%0d_bcd", i), bcd, vq[i].bcd);
      chk($sformatf("v%0d_run", i), {15'd0, running}, {15'd0, vq[i].run});
      chk($sformatf("v%0d_tick", i), {15'd0, tick}, {15'd0, vq[i].tick});
      chk($sformatf("v%0d_wrap", i), {15'd0, wrap}, {15'd0, vq[i].wrap});
    end

    // Test 3: digit carry and full rollover
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    tick_n(9);
    chk("pre9", bcd, 16'h0009);
    tick_n(1);
    chk("carry10", bcd, 16'h0010);
    tick_n(9989);
    chk("at9999", bcd, 16'h9999);
    chk("at9999_wrap", {15'd0, wrap}, 16'd0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("wrap_bcd", bcd, 16'h0000);
    chk("wrap_hi", {15'd0, wrap}, 16'd1);
    chk("wrap_run", {15'd0, running}, 16'd1);
    step(0, 0, 0, 0);
    chk("wrap_lo", {15'd0, wrap}, 16'd0);

    // Test 4: stop and clear coinciding with a tick
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    tick_n(7);
    chk("pre_stop", bcd, 16'h0007);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("stop_tick_bcd", bcd, 16'h0007);
    chk("stop_tick_run", {15'd0, running}, 16'd0);
    chk("stop_tick_tick", {15'd0, tick}, 16'd1);
    step(0, 0, 0, 0);
    tick_n(2);
    chk("paused_bcd", bcd, 16'h0007);
    step(1, 0, 0, 0);
    tick_n(35);
    chk("pre_clear", bcd, 16'h0042);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("clr_tick_bcd", bcd, 16'h0000);
    chk("clr_tick_run", {15'd0, running}, 16'd0);
    chk("clr_tick_tick", {15'd0, tick}, 16'd1);
    step(0, 0, 0, 0);
    tick_n(1);
    chk("idle_hold", bcd, 16'h0000);

    // start with a tick in IDLE: that tick is not counted
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("start_tick_bcd", bcd, 16'h0000);
    chk("start_tick_run", {15'd0, running}, 16'd1);
    step(0, 0, 0, 0);
    tick_n(1);
    chk("start_next", bcd, 16'h0001);

    // Test 5: asynchronous reset mid-RUN
    tick_n(122);
    chk("pre_rst_bcd", bcd, 16'h0123);
    chk("pre_rst_run", {15'd0, running}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bcd", bcd, 16'h0000);
    chk("arst_run", {15'd0, running}, 16'd0);
    slow = 1'b1;
    #3;
    rst_n = 1'b1;
    tc = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      if (tick) tc++;
    end
    chk("post_rst_ticks", tc[15:0], 16'd1);
    chk("post_rst_bcd", bcd, 16'h0000);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

`ifdef LAP_HOLD_EN
    // Test 6: lap freeze
    step(1, 0, 0, 0);
    tick_n(30);
    chk("pre_lap", bcd, 16'h0030);
    lap = 1'b1;
    step(0, 0, 0, 0);
    lap = 1'b0;
    tick_n(4);
    chk("lap_hold", bcd, 16'h0030);
    lap = 1'b1;
    step(0, 0, 0, 0);
    lap = 1'b0;
    step(0, 0, 0, 0);
    chk("lap_release", bcd, 16'h0034);
    lap = 1'b1;
    step(0, 0, 0, 0);
    lap = 1'b0;
    tick_n(1);
    chk("lap_hold2", bcd, 16'h0034);
    step(0, 0, 1, 0);
    chk("lap_clear", bcd, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
